// File: rtl/bkg_scroll_reader.sv
// Background image read engine: pixel coordinates plus vertical scroll
// to a background RAM address, with a delay-aligned colour output.
module bkg_scroll_reader #(
    parameter int IMG_W      = 80,
    parameter int IMG_H      = 96,
    parameter int X_SHIFT    = 3,
    parameter int Y_SHIFT    = 2,
    parameter int SCROLL_MOD = 384
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        pix_valid,
    input  logic        frame_start,
    input  logic        scroll_req,
    input  logic [8:0]  scroll_amt,
    output logic        scroll_ack,
    output logic [8:0]  scroll_y,
    output logic [12:0] rd_addr,
    input  logic [23:0] ram_data,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        out_valid
);

    localparam logic [10:0] MOD1 = 11'(SCROLL_MOD);
    localparam logic [10:0] MOD2 = 11'(2 * SCROLL_MOD);

    logic        pending;
    logic [8:0]  pend_amt;
    logic        v1;
    logic        v2;

    logic [10:0] yy;
    logic [8:0]  ym;
    logic [6:0]  row;
    logic [6:0]  col;
    logic [12:0] addr_nxt;

    logic [10:0] fs_sum;
    logic [10:0] pend_sum;
    logic [8:0]  scroll_nxt;
    logic [8:0]  pend_nxt;

    // Reduce a sum below 3*SCROLL_MOD into 0..SCROLL_MOD-1 with compares only.
    function automatic logic [8:0] mod_red(input logic [10:0] s);
        if (s >= MOD2)
            return 9'(s - MOD2);
        else if (s >= MOD1)
            return 9'(s - MOD1);
        else
            return 9'(s);
    endfunction

    // Address path: wrap the scrolled row, scale to texels, row*80 + col.
    always_comb begin
        yy       = 11'(draw_y) + 11'(scroll_y);
        ym       = mod_red(yy);
        row      = 7'(ym >> Y_SHIFT);
        col      = 7'(draw_x >> X_SHIFT);
        addr_nxt = 13'({row, 6'b0}) + 13'({row, 4'b0}) + 13'(col);
    end

    // Scroll arithmetic: the frame-start sum folds in a coincident request.
    always_comb begin
        fs_sum     = 11'(scroll_y) + 11'(pend_amt)
                   + (scroll_req ? 11'(scroll_amt) : 11'd0);
        pend_sum   = 11'(pend_amt) + 11'(scroll_amt);
        scroll_nxt = mod_red(fs_sum);
        pend_nxt   = mod_red(pend_sum);
    end

    // Stage 1 address register and the two-stage valid pipeline.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_addr <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
        end else begin
            rd_addr <= addr_nxt;
            v1      <= pix_valid;
            v2      <= v1;
        end
    end

    // Accumulate scroll requests; apply them only at frame start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            scroll_y   <= '0;
            pending    <= 1'b0;
            pend_amt   <= '0;
            scroll_ack <= 1'b0;
        end else begin
            scroll_ack <= 1'b0;
            if (frame_start) begin
                if (pending || scroll_req) begin
                    scroll_y   <= scroll_nxt;
                    pending    <= 1'b0;
                    pend_amt   <= '0;
                    scroll_ack <= 1'b1;
                end
            end else if (scroll_req) begin
                pending  <= 1'b1;
                pend_amt <= pend_nxt;
            end
        end
    end

    assign out_valid          = v2;
    assign {red, green, blue} = v2 ? ram_data : 24'h0;

endmodule

// File: tb/tb_bkg_scroll_reader.sv
// Self-checking bench for bkg_scroll_reader: directed plan items plus
// randomized pixel and scroll traffic against an arithmetic model.
module tb_bkg_scroll_reader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic        pix_valid;
    logic        frame_start;
    logic        scroll_req;
    logic [8:0]  scroll_amt;
    logic        scroll_ack;
    logic [8:0]  scroll_y;
    logic [12:0] rd_addr;
    logic [23:0] ram_data;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        out_valid;

    logic [23:0] mem [0:7679];

    int checks   = 0;
    int failures = 0;

    int m_scroll;
    int m_pamt;
    bit m_pend;
    bit m_ack;

    bkg_scroll_reader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .scroll_req (scroll_req),
        .scroll_amt (scroll_amt),
        .scroll_ack (scroll_ack),
        .scroll_y   (scroll_y),
        .rd_addr    (rd_addr),
        .ram_data   (ram_data),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .out_valid  (out_valid)
    );

    always #5 Clk = ~Clk;

    // Registered-read background RAM.
    always @(posedge Clk)
        ram_data <= (rd_addr < 13'd7680) ? mem[rd_addr] : 24'h0;

    function automatic int exp_addr(int x, int y, int s);
        int ym;
        ym = (y + s) % 384;
        return (ym / 4) * 80 + x / 8;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_scroll = 0;
        m_pamt   = 0;
        m_pend   = 0;
        m_ack    = 0;
    endtask

    task automatic apply_reset();
        pix_valid   = 0;
        scroll_req  = 0;
        frame_start = 0;
        Reset       = 1;
        tick();
        Reset = 0;
        model_reset();
    endtask

    task automatic scroll_cycle(bit req, int amt, bit fs);
        scroll_req  = req;
        scroll_amt  = 9'(amt);
        frame_start = fs;
        tick();
        m_ack = 0;
        if (fs) begin
            if (m_pend || req) begin
                m_scroll = (m_scroll + m_pamt + (req ? amt : 0)) % 384;
                m_pend   = 0;
                m_pamt   = 0;
                m_ack    = 1;
            end
        end else if (req) begin
            m_pend = 1;
            m_pamt = (m_pamt + amt) % 384;
        end
        scroll_req  = 0;
        frame_start = 0;
    endtask

    task automatic test_reset();
        checks++;
        if (scroll_y !== 9'd0) begin
            failures++;
            $display("FAIL reset_scroll_y got=%0d exp=0", scroll_y);
        end
        checks++;
        if (scroll_ack !== 1'b0 || rd_addr !== 13'd0) begin
            failures++;
            $display("FAIL reset_ack_addr got=%b/%0d exp=0/0", scroll_ack, rd_addr);
        end
        checks++;
        if (out_valid !== 1'b0 || {red, green, blue} !== 24'h0) begin
            failures++;
            $display("FAIL reset_out got=%b/%h exp=0/0", out_valid, {red, green, blue});
        end
        Reset = 0;
        model_reset();
    endtask

    task automatic test_first_pixel();
        draw_x    = 10'd8;
        draw_y    = 10'd4;
        pix_valid = 1;
        tick();
        checks++;
        if (rd_addr !== 13'd81) begin
            failures++;
            $display("FAIL first_addr got=%0d exp=81", rd_addr);
        end
        pix_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || {red, green, blue} !== mem[81]) begin
            failures++;
            $display("FAIL first_rgb got=%b/%h exp=1/%h", out_valid, {red, green, blue}, mem[81]);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || {red, green, blue} !== 24'h0) begin
            failures++;
            $display("FAIL first_drop got=%b/%h exp=0/0", out_valid, {red, green, blue});
        end
    endtask

    task automatic test_corners();
        int xs [5] = '{0, 639, 639, 0, 639};
        int ys [5] = '{0, 0, 383, 384, 479};
        int ea [5] = '{0, 79, 7679, 0, 1919};
        pix_valid = 1;
        for (int i = 0; i < 5; i++) begin
            draw_x = 10'(xs[i]);
            draw_y = 10'(ys[i]);
            tick();
            checks++;
            if (rd_addr !== 13'(ea[i])) begin
                failures++;
                $display("FAIL corner_%0d got=%0d exp=%0d", i, rd_addr, ea[i]);
            end
        end
        pix_valid = 0;
    endtask

    task automatic test_scroll_380();
        scroll_cycle(1, 380, 0);
        checks++;
        if (scroll_y !== 9'd0 || scroll_ack !== 1'b0) begin
            failures++;
            $display("FAIL s380_pre got=%0d/%b exp=0/0", scroll_y, scroll_ack);
        end
        scroll_cycle(0, 0, 1);
        checks++;
        if (scroll_y !== 9'd380 || scroll_ack !== 1'b1) begin
            failures++;
            $display("FAIL s380_apply got=%0d/%b exp=380/1", scroll_y, scroll_ack);
        end
        draw_x = 10'd639;
        draw_y = 10'd479;
        tick();
        checks++;
        if (scroll_ack !== 1'b0) begin
            failures++;
            $display("FAIL s380_ack_once got=%b exp=0", scroll_ack);
        end
        checks++;
        if (rd_addr !== 13'd1839) begin
            failures++;
            $display("FAIL s380_addr got=%0d exp=1839", rd_addr);
        end
    endtask

    task automatic test_two_requests();
        apply_reset();
        scroll_cycle(1, 300, 0);
        scroll_cycle(1, 200, 0);
        checks++;
        if (scroll_y !== 9'd0 || scroll_ack !== 1'b0) begin
            failures++;
            $display("FAIL two_pre got=%0d/%b exp=0/0", scroll_y, scroll_ack);
        end
        scroll_cycle(0, 0, 1);
        checks++;
        if (scroll_y !== 9'd116 || scroll_ack !== 1'b1) begin
            failures++;
            $display("FAIL two_apply got=%0d/%b exp=116/1", scroll_y, scroll_ack);
        end
        scroll_cycle(0, 0, 0);
        checks++;
        if (scroll_ack !== 1'b0 || scroll_y !== 9'd116) begin
            failures++;
            $display("FAIL two_after got=%0d/%b exp=116/0", scroll_y, scroll_ack);
        end
    endtask

    task automatic test_coincident();
        int old;
        scroll_cycle(1, 5, 0);
        old = m_scroll;
        scroll_cycle(1, 10, 1);
        checks++;
        if (scroll_y !== 9'((old + 15) % 384) || scroll_ack !== 1'b1) begin
            failures++;
            $display("FAIL coinc got=%0d/%b exp=%0d/1", scroll_y, scroll_ack, (old + 15) % 384);
        end
        scroll_cycle(0, 0, 1);
        checks++;
        if (scroll_ack !== 1'b0 || scroll_y !== 9'((old + 15) % 384)) begin
            failures++;
            $display("FAIL idle_fs got=%0d/%b exp=%0d/0", scroll_y, scroll_ack, (old + 15) % 384);
        end
    endtask

    task automatic test_random_scroll(int n);
        bit req;
        bit fs;
        int amt;
        for (int i = 0; i < n; i++) begin
            req = ($urandom % 3) == 0;
            fs  = ($urandom % 6) == 0;
            amt = $urandom_range(0, 383);
            scroll_cycle(req, amt, fs);
            checks++;
            if (scroll_y !== 9'(m_scroll) || scroll_ack !== m_ack) begin
                failures++;
                $display("FAIL rnd_scroll_%0d got=%0d/%b exp=%0d/%b",
                         i, scroll_y, scroll_ack, m_scroll, m_ack);
            end
        end
    endtask

    task automatic test_pixel_stream(int n);
        int x;
        int y;
        int a;
        int pa;
        bit v;
        bit pv;
        logic [23:0] er;
        pa = 0;
        pv = 0;
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
            v = ($urandom % 4) != 0;
            a = exp_addr(x, y, m_scroll);
            draw_x    = 10'(x);
            draw_y    = 10'(y);
            pix_valid = v;
            tick();
            checks++;
            if (rd_addr !== 13'(a)) begin
                failures++;
                $display("FAIL pix_addr_%0d got=%0d exp=%0d", i, rd_addr, a);
            end
            if (i > 0) begin
                er = pv ? mem[pa] : 24'h0;
                checks++;
                if (out_valid !== pv || {red, green, blue} !== er) begin
                    failures++;
                    $display("FAIL pix_rgb_%0d got=%b/%h exp=%b/%h",
                             i, out_valid, {red, green, blue}, pv, er);
                end
            end
            pa = a;
            pv = v;
        end
        pix_valid = 0;
        tick();
    endtask

    task automatic test_valid_toggle_reset();
        int a0;
        int a2;
        a0 = exp_addr(100, 200, m_scroll);
        a2 = exp_addr(300, 50, m_scroll);
        draw_x = 10'd100; draw_y = 10'd200; pix_valid = 1;
        tick();
        draw_x = 10'd500; draw_y = 10'd10; pix_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || {red, green, blue} !== mem[a0]) begin
            failures++;
            $display("FAIL tog_1 got=%b/%h exp=1/%h", out_valid, {red, green, blue}, mem[a0]);
        end
        draw_x = 10'd300; draw_y = 10'd50; pix_valid = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || {red, green, blue} !== 24'h0) begin
            failures++;
            $display("FAIL tog_0 got=%b/%h exp=0/0", out_valid, {red, green, blue});
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || {red, green, blue} !== mem[a2]) begin
            failures++;
            $display("FAIL tog_2 got=%b/%h exp=1/%h", out_valid, {red, green, blue}, mem[a2]);
        end
        #2;
        Reset = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || {red, green, blue} !== 24'h0 || scroll_y !== 9'd0) begin
            failures++;
            $display("FAIL async_rst got=%b/%h/%0d exp=0/0/0",
                     out_valid, {red, green, blue}, scroll_y);
        end
        model_reset();
        pix_valid = 0;
        tick();
        Reset = 0;
        tick();
        draw_x = 10'd8; draw_y = 10'd4; pix_valid = 1;
        tick();
        pix_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || rd_addr !== 13'd81) begin
            failures++;
            $display("FAIL post_rst_1 got=%b/%0d exp=0/81", out_valid, rd_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || {red, green, blue} !== mem[81]) begin
            failures++;
            $display("FAIL post_rst_2 got=%b/%h exp=1/%h", out_valid, {red, green, blue}, mem[81]);
        end
    endtask

    initial begin
        for (int i = 0; i < 7680; i++)
            mem[i] = 24'($urandom);
        Reset       = 1;
        draw_x      = 0;
        draw_y      = 0;
        pix_valid   = 0;
        frame_start = 0;
        scroll_req  = 0;
        scroll_amt  = 0;
        model_reset();
        tick();
        tick();
        test_reset();
        test_first_pixel();
        test_corners();
        test_scroll_380();
        test_two_requests();
        test_coincident();
        test_pixel_stream(200);
        test_random_scroll(300);
        test_pixel_stream(200);
        test_random_scroll(300);
        test_pixel_stream(200);
        scroll_cycle(1, 50, 0);
        scroll_cycle(0, 0, 1);
        test_valid_toggle_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
